// File: rtl/sh_pkg.sv
// Shared shift-kind encoding and multi-cycle shifter FSM states.
// Decoded SH fields from control drive the shifters without translation.
package sh_pkg;

  localparam int SH_WIDTH = 16;
  localparam int SH_CNT_W = 4;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSR  = 2'b01,
    SH_LSL  = 2'b10,
    SH_ASR  = 2'b11
  } sh_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } sh_state_e;

  // SH_NONE requests a pass-through, so its amount is forced to zero.
  function automatic logic [SH_CNT_W-1:0] sh_eff_count(sh_mode_e m, logic [SH_CNT_W-1:0] amt);
    return (m == SH_NONE) ? '0 : amt;
  endfunction

endpackage

// File: rtl/multi_shift_unit_if.sv
// Request/response bundle between the control unit and multi_shift_unit.
interface multi_shift_unit_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [1:0]       mode;
  logic [CNT_W-1:0] amount;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;

  modport master (
    output start, data_in, mode, amount,
    input  busy, done, result, carry, zero
  );

  modport slave (
    input  start, data_in, mode, amount,
    output busy, done, result, carry, zero
  );
endinterface

// File: rtl/multi_shift_unit_step.sv
// One-bit combinational shift step; carry_o is the bit pushed out.
module shift_step
  import sh_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] val_i,
  input  sh_mode_e         mode_i,
  output logic [WIDTH-1:0] val_o,
  output logic             carry_o
);

  always_comb begin
    val_o   = val_i;
    carry_o = 1'b0;
    case (mode_i)
      SH_LSR: begin
        val_o   = {1'b0, val_i[WIDTH-1:1]};
        carry_o = val_i[0];
      end
      SH_LSL: begin
        val_o   = {val_i[WIDTH-2:0], 1'b0};
        carry_o = val_i[WIDTH-1];
      end
      SH_ASR: begin
        val_o   = {val_i[WIDTH-1], val_i[WIDTH-1:1]};
        carry_o = val_i[0];
      end
      default: begin
        val_o   = val_i;
        carry_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multi_shift_unit.sv
// Multi-cycle shifter: one bit per clock, 0..2^CNT_W-1 positions.
// Control issues start, stalls on busy, writes result back on the done pulse.
module multi_shift_unit
  import sh_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  multi_shift_unit_if.slave bus
);

  sh_state_e        state_q, state_d;
  sh_mode_e         mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] step_val;
  logic             step_carry;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .val_i   (result_q),
    .mode_i  (mode_q),
    .val_o   (step_val),
    .carry_o (step_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= SH_NONE;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mode_d   = sh_mode_e'(bus.mode);
          cnt_d    = CNT_W'(sh_eff_count(sh_mode_e'(bus.mode), SH_CNT_W'(bus.amount)));
          result_d = bus.data_in;
          carry_d  = 1'b0;
          state_d  = (cnt_d != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        result_d = step_val;
        carry_d  = step_carry;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Tracks result on every load so it is already valid in the DONE cycle.
    zero_d = (result_d == '0);
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_multi_shift_unit.sv
// Randomized self-checking bench for multi_shift_unit against an arithmetic shift model.
module tb_multi_shift_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  multi_shift_unit_if #(.WIDTH(16), .CNT_W(4)) bus ();

  multi_shift_unit #(.WIDTH(16), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole shift in one step from the mode rules.
  function automatic void model(input logic [15:0] d, input logic [1:0] m, input logic [3:0] a,
                                output logic [15:0] r, output logic c, output int n);
    n = (m == 2'b00) ? 0 : int'(a);
    r = d;
    c = 1'b0;
    if (n > 0) begin
      case (m)
        2'b01: begin r = d >> n; c = d[n-1]; end
        2'b10: begin r = 16'(d << n); c = d[16-n]; end
        default: begin r = 16'($signed(d) >>> n); c = d[n-1]; end
      endcase
    end
  endfunction

  task automatic check_reset_vals(input string nm);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 16'h0000 ||
        bus.carry !== 1'b0 || bus.zero !== 1'b1) begin
      failures++;
      $display("FAIL %s: busy=%b done=%b result=%h carry=%b zero=%b, required 0 0 0000 0 1",
               nm, bus.busy, bus.done, bus.result, bus.carry, bus.zero);
    end
  endtask

  // Issues one request in the current cycle and checks every cycle through the return to IDLE.
  task automatic run_op(input logic [15:0] d, input logic [1:0] m, input logic [3:0] a,
                        input bit noise, input string nm);
    logic [15:0] er;
    logic        ec;
    int          n;
    model(d, m, a, er, ec, n);
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.mode    = m;
    bus.amount  = a;
    @(posedge clk); #1;
    for (int k = 1; k <= n + 1; k++) begin
      if (noise) begin
        bus.start   = 1'b1;
        bus.data_in = 16'($urandom);
        bus.mode    = 2'($urandom);
        bus.amount  = 4'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== (k == n + 1)) begin
        failures++;
        $display("FAIL %s cycle t+%0d: busy=%b done=%b, required busy=1 done=%b",
                 nm, k, bus.busy, bus.done, (k == n + 1));
      end
      if (k == n + 1) begin
        checks++;
        if (bus.result !== er || bus.carry !== ec || bus.zero !== (er == 16'h0)) begin
          failures++;
          $display("FAIL %s result: got %h c=%b z=%b, required %h c=%b z=%b",
                   nm, bus.result, bus.carry, bus.zero, er, ec, (er == 16'h0));
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== er ||
        bus.carry !== ec || bus.zero !== (er == 16'h0)) begin
      failures++;
      $display("FAIL %s idle-hold: busy=%b done=%b result=%h c=%b, required 0 0 %h %b",
               nm, bus.busy, bus.done, bus.result, bus.carry, er, ec);
    end
  endtask

  task automatic test_reset();
    check_reset_vals("reset_initial");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h00FF, 2'b10, 4'd2, 1'b0, "pre_reset_op");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_async");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lsl();
    run_op(16'h0001, 2'b10, 4'd4, 1'b0, "lsl_1x4");
  endtask

  task automatic test_right();
    run_op(16'hF00F, 2'b01, 4'd4, 1'b0, "lsr_f00f_4");
    run_op(16'h8001, 2'b11, 4'd1, 1'b0, "asr_8001_1");
  endtask

  task automatic test_boundary();
    run_op(16'h8000, 2'b10, 4'd1, 1'b0, "lsl_8000_1");
    run_op(16'h1234, 2'b00, 4'd7, 1'b0, "none_amt7");
    run_op(16'hA5A5, 2'b01, 4'd0, 1'b0, "lsr_amt0");
    run_op(16'hFFFF, 2'b10, 4'd15, 1'b0, "lsl_max");
    run_op(16'hFFFF, 2'b01, 4'd15, 1'b0, "lsr_max");
    run_op(16'h8000, 2'b11, 4'd15, 1'b0, "asr_max");
  endtask

  task automatic test_ignore_busy();
    run_op(16'h00F0, 2'b01, 4'd3, 1'b1, "busy_start_ignored");
  endtask

  task automatic test_reset_mid();
    bus.start = 1'b1; bus.data_in = 16'h1357; bus.mode = 2'b10; bus.amount = 4'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_hold: busy=%b done=%b, required 0 0", bus.busy, bus.done);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h0F0F, 2'b11, 4'd5, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      run_op(16'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_back_to_back();
    run_op(16'h8421, 2'b11, 4'd3, 1'b1, "b2b_a");
    run_op(16'h0000, 2'b10, 4'd2, 1'b0, "b2b_zero");
    run_op(16'h7FFF, 2'b11, 4'd14, 1'b1, "b2b_c");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.data_in = '0;
    bus.mode = '0;
    bus.amount = '0;
    #12;
    test_reset();
    test_lsl();
    test_right();
    test_boundary();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
